ysyx_mem_arbiter: RTL

//  Shares the single data-memory port between the IFU (fetch, read-only) and the LSU (load/store).

---
 rtl/ysyx_mem_pkg.sv | 27 ++
 rtl/ysyx_rr_arbiter2.sv | 42 ++++
 rtl/ysyx_mem_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/ysyx_mem_pkg.sv
// Shared types and constants for the IFU/LSU data-memory arbiter.
//   state_e : arbiter FSM states
//   owner_e : which requester owns the outstanding transaction
//   ARB_*   : arbitration mode selectors
//   WMASK_* : legal LSU byte masks (byte / half / word)
package ysyx_mem_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      IFU  = 2'd1,
      LSU  = 2'd2
   } owner_e;

   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   localparam logic [3:0] WMASK_B = 4'b0001;
   localparam logic [3:0] WMASK_H = 4'b0011;
   localparam logic [3:0] WMASK_W = 4'b1111;

endpackage

// File: rtl/ysyx_rr_arbiter2.sv
// Two-requester grant logic (IFU vs LSU), purely combinational.
//   en          : arbitration allowed this cycle (arbiter idle, not in reset)
//   req_ifu     : IFU request valid
//   req_lsu     : LSU request valid
//   rr_last_lsu : 1 when the LSU won the previous grant, 0 when the IFU did
//   gnt_ifu     : IFU granted
//   gnt_lsu     : LSU granted
// ARB_MODE selects fixed LSU priority or round-robin on a tie.
module ysyx_rr_arbiter2
   import ysyx_mem_pkg::*;
#(
   parameter int ARB_MODE = ARB_RR
) (
   input  logic en,
   input  logic req_ifu,
   input  logic req_lsu,
   input  logic rr_last_lsu,
   output logic gnt_ifu,
   output logic gnt_lsu
);

   always_comb begin
      gnt_ifu = 1'b0;
      gnt_lsu = 1'b0;
      if (en) begin
         if (req_ifu && req_lsu) begin
            // Tie: fixed mode favours the LSU, round-robin favours whoever did not win last.
            if (ARB_MODE == ARB_FIXED) begin
               gnt_lsu = 1'b1;
            end else if (rr_last_lsu) begin
               gnt_ifu = 1'b1;
            end else begin
               gnt_lsu = 1'b1;
            end
         end else begin
            gnt_ifu = req_ifu;
            gnt_lsu = req_lsu;
         end
      end
   end

endmodule

// File: rtl/ysyx_mem_arbiter.sv
// Shares one valid/ready data-memory port between the IFU (read-only fetch)
// and the LSU (load/store). One transaction is outstanding at a time; the
// response is routed back to the owner as a one-cycle pulse, and a
// transaction that sits in ISSUE+WAIT for TIMEOUT_CYCLES cycles returns an
// error pulse instead.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   ifu_req_valid/ready, ifu_addr   : IFU request (ready is combinational)
//   ifu_rsp_valid/rdata/rsp_err     : IFU response pulse
//   lsu_req_valid/ready, lsu_addr,
//   lsu_wen/wdata/wmask             : LSU request (ready is combinational)
//   lsu_rsp_valid/rdata/rsp_err     : LSU response pulse (rdata 0 for stores)
//   mem_req_valid/ready, mem_addr,
//   mem_wen/wdata/wmask             : request to memory, fields latched at grant
//   mem_rsp_valid, mem_rdata        : memory response
//
// state | meaning
// IDLE  | no transaction; arbitrate and capture the winner's request
// ISSUE | mem_req_valid high, waiting for mem_req_ready
// WAIT  | request accepted, waiting for mem_rsp_valid
module ysyx_mem_arbiter
   import ysyx_mem_pkg::*;
#(
   parameter int ARB_MODE       = 1,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TW             = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ifu_req_valid,
   output logic        ifu_req_ready,
   input  logic [31:0] ifu_addr,
   output logic        ifu_rsp_valid,
   output logic [31:0] ifu_rdata,
   output logic        ifu_rsp_err,
   input  logic        lsu_req_valid,
   output logic        lsu_req_ready,
   input  logic [31:0] lsu_addr,
   input  logic        lsu_wen,
   input  logic [31:0] lsu_wdata,
   input  logic [3:0]  lsu_wmask,
   output logic        lsu_rsp_valid,
   output logic [31:0] lsu_rdata,
   output logic        lsu_rsp_err,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_addr,
   output logic        mem_wen,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rdata
);

   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

   state_e        state_q, state_d;
   owner_e        owner_q;
   logic          rr_last_lsu_q;
   logic [TW-1:0] timer_q;

   logic arb_en;
   logic gnt_ifu, gnt_lsu, grant;
   logic timeout_hit;
   logic rsp_fire, to_fire;

   assign arb_en      = (state_q == IDLE) && !rst;
   assign timeout_hit = (state_q != IDLE) && (timer_q == TIMER_LAST);

   ysyx_rr_arbiter2 #(
      .ARB_MODE (ARB_MODE)
   ) u_arb (
      .en          (arb_en),
      .req_ifu     (ifu_req_valid),
      .req_lsu     (lsu_req_valid),
      .rr_last_lsu (rr_last_lsu_q),
      .gnt_ifu     (gnt_ifu),
      .gnt_lsu     (gnt_lsu)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (gnt_ifu || gnt_lsu) state_d = ISSUE;
         end
         ISSUE: begin
            if (timeout_hit)        state_d = IDLE;
            else if (mem_req_ready) state_d = WAIT;
         end
         WAIT: begin
            if (mem_rsp_valid || timeout_hit) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ifu_req_ready = gnt_ifu;
      lsu_req_ready = gnt_lsu;
      grant         = gnt_ifu || gnt_lsu;
      // A response wins over a timeout landing in the same cycle.
      rsp_fire      = (state_q == WAIT) && mem_rsp_valid;
      to_fire       = timeout_hit && !rsp_fire;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q       <= NONE;
         rr_last_lsu_q <= 1'b0;
         timer_q       <= '0;
         mem_req_valid <= 1'b0;
         mem_addr      <= '0;
         mem_wen       <= 1'b0;
         mem_wdata     <= '0;
         mem_wmask     <= '0;
         ifu_rsp_valid <= 1'b0;
         ifu_rdata     <= '0;
         ifu_rsp_err   <= 1'b0;
         lsu_rsp_valid <= 1'b0;
         lsu_rdata     <= '0;
         lsu_rsp_err   <= 1'b0;
      end else begin
         mem_req_valid <= (state_d == ISSUE);
         ifu_rsp_valid <= 1'b0;
         ifu_rdata     <= '0;
         ifu_rsp_err   <= 1'b0;
         lsu_rsp_valid <= 1'b0;
         lsu_rdata     <= '0;
         lsu_rsp_err   <= 1'b0;

         if (grant) begin
            owner_q       <= gnt_lsu ? LSU : IFU;
            rr_last_lsu_q <= gnt_lsu;
            timer_q       <= '0;
            // Fetches are always word reads with no write payload.
            mem_addr      <= gnt_lsu ? lsu_addr : ifu_addr;
            mem_wen       <= gnt_lsu && lsu_wen;
            mem_wdata     <= gnt_lsu ? lsu_wdata : 32'h0;
            mem_wmask     <= gnt_lsu ? lsu_wmask : 4'b0000;
         end else if (state_q != IDLE) begin
            timer_q <= timer_q + TW'(1);
         end

         if (rsp_fire || to_fire) begin
            owner_q <= NONE;
            timer_q <= '0;
            if (owner_q == IFU) begin
               ifu_rsp_valid <= 1'b1;
               ifu_rsp_err   <= to_fire;
               ifu_rdata     <= rsp_fire ? mem_rdata : 32'h0;
            end
            if (owner_q == LSU) begin
               lsu_rsp_valid <= 1'b1;
               lsu_rsp_err   <= to_fire;
               lsu_rdata     <= (rsp_fire && !mem_wen) ? mem_rdata : 32'h0;
            end
         end
      end
   end

endmodule
